// File: rtl/router_fsm.sv
// Control FSM for a 1-input, 3-output packet router: decodes the header address,
// sequences header/payload/parity loads and handles FIFO back-pressure and soft resets.
module router_fsm (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic       fifo_full,
    input  logic       parity_done,
    input  logic       low_packet_valid,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] soft_reset,
    input  logic [1:0] data_in,
    output logic       write_enb_reg,
    output logic       detect_add,
    output logic       ld_state,
    output logic       lfd_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       reset_int_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'b000,
        LOAD_FIRST_DATA    = 3'b001,
        WAIT_TILL_EMPTY    = 3'b010,
        LOAD_DATA          = 3'b011,
        FIFO_FULL_STATE    = 3'b100,
        LOAD_PARITY        = 3'b101,
        LOAD_AFTER_FULL    = 3'b110,
        CHECK_PARITY_ERROR = 3'b111
    } state_t;

    state_t     state;
    logic [1:0] addr;

    // Pad the per-port flags to four entries so address 2'b11 reads as inactive.
    logic [3:0] empty_pad;
    logic [3:0] soft_pad;
    assign empty_pad = {1'b0, fifo_empty};
    assign soft_pad  = {1'b0, soft_reset};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= DECODE_ADDRESS;
            addr  <= 2'b00;
        end else begin
            if (state == DECODE_ADDRESS && pkt_valid)
                addr <= data_in;

            if (state != DECODE_ADDRESS && soft_pad[addr]) begin
                state <= DECODE_ADDRESS;
            end else begin
                case (state)
                    DECODE_ADDRESS: begin
                        if (pkt_valid && data_in != 2'b11) begin
                            if (empty_pad[data_in])
                                state <= LOAD_FIRST_DATA;
                            else
                                state <= WAIT_TILL_EMPTY;
                        end
                    end
                    LOAD_FIRST_DATA: state <= LOAD_DATA;
                    WAIT_TILL_EMPTY: begin
                        if (empty_pad[addr])
                            state <= LOAD_FIRST_DATA;
                    end
                    LOAD_DATA: begin
                        if (fifo_full)
                            state <= FIFO_FULL_STATE;
                        else if (!pkt_valid)
                            state <= LOAD_PARITY;
                    end
                    FIFO_FULL_STATE: begin
                        if (!fifo_full)
                            state <= LOAD_AFTER_FULL;
                    end
                    LOAD_AFTER_FULL: begin
                        if (parity_done)
                            state <= DECODE_ADDRESS;
                        else if (low_packet_valid)
                            state <= LOAD_PARITY;
                        else
                            state <= LOAD_DATA;
                    end
                    LOAD_PARITY: state <= CHECK_PARITY_ERROR;
                    CHECK_PARITY_ERROR: begin
                        if (fifo_full)
                            state <= FIFO_FULL_STATE;
                        else
                            state <= DECODE_ADDRESS;
                    end
                    default: state <= DECODE_ADDRESS;
                endcase
            end
        end
    end

    assign detect_add    = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign reset_int_reg = (state == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY)
                         || (state == LOAD_AFTER_FULL);
    assign busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// Directed self-checking bench for router_fsm; each state is identified by its
// full output vector {detect_add,lfd,ld,full,laf,reset_int,write_enb,busy}.
module tb_router_fsm;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic       fifo_full;
    logic       parity_done;
    logic       low_packet_valid;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic       detect_add;
    logic       ld_state;
    logic       lfd_state;
    logic       laf_state;
    logic       full_state;
    logic       reset_int_reg;
    logic       busy;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] EXP_DA  = 8'b1000_0000;
    localparam logic [7:0] EXP_LFD = 8'b0100_0001;
    localparam logic [7:0] EXP_LD  = 8'b0010_0010;
    localparam logic [7:0] EXP_FFS = 8'b0001_0001;
    localparam logic [7:0] EXP_LAF = 8'b0000_1011;
    localparam logic [7:0] EXP_CPE = 8'b0000_0101;
    localparam logic [7:0] EXP_WTE = 8'b0000_0001;
    localparam logic [7:0] EXP_LP  = 8'b0000_0011;

    router_fsm dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .fifo_full        (fifo_full),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .fifo_empty       (fifo_empty),
        .soft_reset       (soft_reset),
        .data_in          (data_in),
        .write_enb_reg    (write_enb_reg),
        .detect_add       (detect_add),
        .ld_state         (ld_state),
        .lfd_state        (lfd_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .reset_int_reg    (reset_int_reg),
        .busy             (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] outVec();
        return {detect_add, lfd_state, ld_state, full_state,
                laf_state, reset_int_reg, write_enb_reg, busy};
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic pv, input logic [1:0] din, input logic [2:0] empty,
                                 input logic full, input logic [2:0] sr,
                                 input logic pd, input logic lpv);
        pkt_valid        = pv;
        data_in          = din;
        fifo_empty       = empty;
        fifo_full        = full;
        soft_reset       = sr;
        parity_done      = pd;
        low_packet_valid = lpv;
    endtask

    task automatic stepCheck(input string tag, input logic [7:0] exp);
        @(posedge clock);
        #1;
        checkOutput(tag, outVec(), exp);
    endtask

    initial begin
        resetn = 1'b1;
        applyStimulus(0, 2'b00, 3'b000, 0, 3'b000, 0, 0);
        repeat (2) @(posedge clock);
        #3 resetn = 1'b0;
        #1 checkOutput("async_reset", outVec(), EXP_DA);
        @(negedge clock);
        resetn = 1'b1;
        stepCheck("idle_stay", EXP_DA);

        // Normal packet to port 1
        applyStimulus(1, 2'b01, 3'b010, 0, 3'b000, 0, 0);
        stepCheck("p1_lfd", EXP_LFD);
        stepCheck("p1_ld", EXP_LD);
        stepCheck("p1_ld_hold", EXP_LD);
        applyStimulus(0, 2'b01, 3'b010, 0, 3'b000, 0, 0);
        stepCheck("p1_lp", EXP_LP);
        stepCheck("p1_cpe", EXP_CPE);
        stepCheck("p1_da", EXP_DA);

        // Full during payload on port 0, low_packet_valid path
        applyStimulus(1, 2'b00, 3'b001, 0, 3'b000, 0, 0);
        stepCheck("p0_lfd", EXP_LFD);
        stepCheck("p0_ld", EXP_LD);
        applyStimulus(1, 2'b00, 3'b001, 1, 3'b000, 0, 0);
        stepCheck("p0_ffs", EXP_FFS);
        stepCheck("p0_ffs_hold", EXP_FFS);
        applyStimulus(0, 2'b00, 3'b001, 0, 3'b000, 0, 1);
        stepCheck("p0_laf", EXP_LAF);
        stepCheck("p0_laf_lp", EXP_LP);
        stepCheck("p0_cpe", EXP_CPE);
        stepCheck("p0_da", EXP_DA);

        // LOAD_AFTER_FULL back to LOAD_DATA, then exit on parity_done
        applyStimulus(1, 2'b00, 3'b001, 0, 3'b000, 0, 0);
        stepCheck("laf2_lfd", EXP_LFD);
        stepCheck("laf2_ld", EXP_LD);
        applyStimulus(1, 2'b00, 3'b001, 1, 3'b000, 0, 0);
        stepCheck("laf2_ffs", EXP_FFS);
        applyStimulus(1, 2'b00, 3'b001, 0, 3'b000, 0, 0);
        stepCheck("laf2_laf", EXP_LAF);
        stepCheck("laf2_back_ld", EXP_LD);
        applyStimulus(1, 2'b00, 3'b001, 1, 3'b000, 0, 0);
        stepCheck("laf3_ffs", EXP_FFS);
        applyStimulus(0, 2'b00, 3'b001, 0, 3'b000, 1, 1);
        stepCheck("laf3_laf", EXP_LAF);
        stepCheck("laf3_pd_da", EXP_DA);

        // Non-empty destination port 2; address must be held while waiting
        applyStimulus(1, 2'b10, 3'b000, 0, 3'b000, 0, 0);
        stepCheck("p2_wte", EXP_WTE);
        applyStimulus(1, 2'b00, 3'b001, 0, 3'b000, 0, 0);
        stepCheck("p2_wte_hold1", EXP_WTE);
        stepCheck("p2_wte_hold2", EXP_WTE);
        stepCheck("p2_wte_hold3", EXP_WTE);
        applyStimulus(1, 2'b00, 3'b100, 0, 3'b000, 0, 0);
        stepCheck("p2_lfd", EXP_LFD);
        stepCheck("p2_ld", EXP_LD);
        applyStimulus(0, 2'b00, 3'b100, 0, 3'b000, 0, 0);
        stepCheck("p2_lp", EXP_LP);
        applyStimulus(0, 2'b00, 3'b100, 1, 3'b000, 0, 0);
        stepCheck("p2_cpe", EXP_CPE);
        stepCheck("p2_cpe_full_ffs", EXP_FFS);
        applyStimulus(0, 2'b00, 3'b100, 0, 3'b000, 1, 0);
        stepCheck("p2_laf", EXP_LAF);
        stepCheck("p2_da", EXP_DA);

        // Soft reset: other port ignored, own port forces DECODE_ADDRESS
        applyStimulus(1, 2'b01, 3'b010, 0, 3'b000, 0, 0);
        stepCheck("sr_lfd", EXP_LFD);
        stepCheck("sr_ld", EXP_LD);
        applyStimulus(1, 2'b01, 3'b010, 0, 3'b001, 0, 0);
        stepCheck("sr_other_port", EXP_LD);
        applyStimulus(1, 2'b01, 3'b010, 0, 3'b010, 0, 0);
        stepCheck("sr_own_port", EXP_DA);
        applyStimulus(1, 2'b11, 3'b111, 0, 3'b000, 0, 0);
        stepCheck("addr11_stay1", EXP_DA);
        stepCheck("addr11_stay2", EXP_DA);

        // Soft reset during WAIT_TILL_EMPTY
        applyStimulus(1, 2'b00, 3'b000, 0, 3'b000, 0, 0);
        stepCheck("sr_wte", EXP_WTE);
        applyStimulus(0, 2'b00, 3'b000, 0, 3'b001, 0, 0);
        stepCheck("sr_wte_da", EXP_DA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control FSM of a 1-input, 3-output packet router.
- Decodes the 2-bit destination address from the header byte and sequences header, payload and parity loading into the router register block.
- Handles destination-FIFO full/empty back-pressure and per-port soft resets.
- Produces Moore control strobes consumed by the register block, the FIFO write-enable logic and the source handshake (busy).

Parameters:
- None.
- State encoding is fixed as localparams: DECODE_ADDRESS=3'b000, LOAD_FIRST_DATA=3'b001, WAIT_TILL_EMPTY=3'b010, LOAD_DATA=3'b011, FIFO_FULL_STATE=3'b100, LOAD_PARITY=3'b101, LOAD_AFTER_FULL=3'b110, CHECK_PARITY_ERROR=3'b111.

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
pkt_valid  in  1  source packet valid; deasserts after last payload byte
fifo_full  in  1  full flag of the currently addressed FIFO
parity_done  in  1  parity byte already loaded (from register block)
low_packet_valid  in  1  pkt_valid dropped while FIFO was full (from register block)
fifo_empty  in  3  per-FIFO empty flags, bit k = FIFO k
soft_reset  in  3  per-FIFO soft-reset (read timeout), bit k = FIFO k
data_in  in  2  header address field (data byte bits [1:0])
write_enb_reg  out  1  write-enable request to FIFO path
detect_add  out  1  in DECODE_ADDRESS
ld_state  out  1  in LOAD_DATA
lfd_state  out  1  in LOAD_FIRST_DATA
laf_state  out  1  in LOAD_AFTER_FULL
full_state  out  1  in FIFO_FULL_STATE
reset_int_reg  out  1  in CHECK_PARITY_ERROR
busy  out  1  router cannot accept a new byte

Behaviour:
- Single state register clocked on rising clock edge.
- resetn=0 asynchronously forces DECODE_ADDRESS. Reset outputs: detect_add=1, all other outputs 0.
- An address register addr[1:0] captures data_in on each clock while in DECODE_ADDRESS with pkt_valid=1. It is held in all other states.
- Soft reset: if soft_reset[addr]=1 at a clock edge while not in DECODE_ADDRESS, next state = DECODE_ADDRESS. This overrides all transitions below.
- Transitions:
  - DECODE_ADDRESS:
    - pkt_valid=1, data_in=k (k in 0..2), fifo_empty[k]=1 -> LOAD_FIRST_DATA.
    - pkt_valid=1, data_in=k, fifo_empty[k]=0 -> WAIT_TILL_EMPTY.
    - data_in=2'b11 or pkt_valid=0 -> stay.
  - LOAD_FIRST_DATA -> LOAD_DATA, unconditionally (one cycle).
  - WAIT_TILL_EMPTY: fifo_empty[addr]=1 -> LOAD_FIRST_DATA; else stay.
  - LOAD_DATA (evaluated in this priority):
    - fifo_full=1 -> FIFO_FULL_STATE.
    - pkt_valid=0 -> LOAD_PARITY.
    - otherwise stay.
  - FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL (evaluated in this priority):
    - parity_done=1 -> DECODE_ADDRESS.
    - low_packet_valid=1 -> LOAD_PARITY.
    - otherwise -> LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR, unconditionally.
  - CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else DECODE_ADDRESS.
- Outputs are pure Moore decodes of the current state, with no registering and no added latency:
  - detect_add = DECODE_ADDRESS
  - lfd_state = LOAD_FIRST_DATA
  - ld_state = LOAD_DATA
  - full_state = FIFO_FULL_STATE
  - laf_state = LOAD_AFTER_FULL
  - reset_int_reg = CHECK_PARITY_ERROR
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA
- Exactly one of detect_add/lfd_state/ld_state/full_state/laf_state/reset_int_reg is high when in the states they decode. All six are 0 in WAIT_TILL_EMPTY and LOAD_PARITY.
- X/undefined state codes are impossible with a 3-bit encoding. The default branch returns to DECODE_ADDRESS.

Test Plan:
- Reset: all inputs 0, resetn pulsed low mid-cycle -> immediate DECODE_ADDRESS; detect_add=1, busy=0, write_enb_reg=0.
- Normal packet to port 1: pkt_valid=1, data_in=01, fifo_empty=3'b010 -> next edges LOAD_FIRST_DATA (lfd_state=1, busy=1), then LOAD_DATA (ld_state=1, write_enb_reg=1, busy=0). Drop pkt_valid with fifo_full=0 -> LOAD_PARITY (write_enb_reg=1, busy=1), then CHECK_PARITY_ERROR (reset_int_reg=1), then DECODE_ADDRESS.
- Full during payload, port 0: in LOAD_DATA set fifo_full=1 -> FIFO_FULL_STATE (full_state=1, busy=1, write_enb_reg=0). With parity_done=0, low_packet_valid=1, clear fifo_full -> LOAD_AFTER_FULL (laf_state=1), then LOAD_PARITY.
- LOAD_AFTER_FULL with parity_done=0, low_packet_valid=0 -> LOAD_DATA. With parity_done=1 -> DECODE_ADDRESS.
- Non-empty destination: data_in=10, fifo_empty[2]=0, pkt_valid=1 -> WAIT_TILL_EMPTY (busy=1). Hold 3 cycles, then set fifo_empty[2]=1 -> LOAD_FIRST_DATA. Also check CHECK_PARITY_ERROR with fifo_full=1 -> FIFO_FULL_STATE.
- Soft reset: in LOAD_DATA for addr=01 assert soft_reset=3'b010 -> DECODE_ADDRESS next edge. soft_reset=3'b001 (other port) -> no effect. data_in=11 with pkt_valid=1 -> stays in DECODE_ADDRESS.
